paralelo_serial_tx: RTL and testbench



---
 rtl/paralelo_serial_tx.sv | 110 +++++++++++
 tb/tb_paralelo_serial_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - byte-to-serial lane with COM training burst and COM idle fill; optional scrambler under SCRAMBLER_EN
module paralelo_serial_tx #(
   parameter logic [7:0] COM_SYMBOL    = 8'hBC,
   parameter int         MIN_COM_COUNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       data_out,
   output logic       load,
   output logic       active,
   output logic       is_data
);

   localparam logic [0:0] TRAIN  = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   localparam logic [3:0] LAST_COM = 4'(MIN_COM_COUNT - 1);

   logic [7:0] shift_reg;
   logic [2:0] bit_cnt;
   logic [3:0] com_cnt;
   logic [0:0] state;
   logic       is_data_q;

   logic [7:0] next_byte;
   logic [7:0] data_word;
   logic       sel_data;

`ifdef SCRAMBLER_EN
   localparam logic [15:0] LFSR_SEED = 16'hFFFF;
   // Galois taps for x^16+x^5+x^4+x^3+1 (x^16 is the shifted-out bit)
   localparam logic [15:0] LFSR_TAPS = 16'h0039;

   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;
   logic [7:0]  scr_byte;
   logic [7:0]  src_byte;

   // Scramble the candidate data byte MSB first, one LFSR step per bit
   always_comb begin
      lfsr_nxt = lfsr;
      src_byte = data_in;
      scr_byte = 8'h00;
      for (int k = 0; k < 8; k++) begin
         scr_byte = {scr_byte[6:0], src_byte[7] ^ lfsr_nxt[15]};
         src_byte = {src_byte[6:0], 1'b0};
         lfsr_nxt = {lfsr_nxt[14:0], 1'b0} ^ (lfsr_nxt[15] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign data_word = scr_byte;

   // LFSR advances only on data loads; every COM load restarts it from the seed
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr <= LFSR_SEED;
      end else if (load) begin
         if (sel_data) begin
            lfsr <= lfsr_nxt;
         end else begin
            lfsr <= LFSR_SEED;
         end
      end
   end
`else
   assign data_word = data_in;
`endif

   assign load     = (bit_cnt == 3'd7);
   assign active   = (state == ACTIVE);
   assign data_out = shift_reg[7];
   assign is_data  = is_data_q;

   // Choose the byte for the next slot: data only when trained and the slot is qualified
   always_comb begin
      next_byte = COM_SYMBOL;
      sel_data  = 1'b0;
      if (state == ACTIVE && valid_in) begin
         next_byte = data_word;
         sel_data  = 1'b1;
      end
   end

   // Shift one bit per clock; on the load slot fetch the next byte and run the training count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_reg <= 8'h00;
         bit_cnt   <= 3'd7;
         com_cnt   <= 4'd0;
         state     <= TRAIN;
         is_data_q <= 1'b0;
      end else if (!load) begin
         shift_reg <= {shift_reg[6:0], 1'b0};
         bit_cnt   <= bit_cnt + 3'd1;
      end else begin
         bit_cnt   <= 3'd0;
         shift_reg <= next_byte;
         is_data_q <= sel_data;
         if (state == TRAIN) begin
            com_cnt <= com_cnt + 4'd1;
            if (com_cnt == LAST_COM) begin
               state <= ACTIVE;
            end
         end
      end
   end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb/tb_paralelo_serial_tx.sv - directed self-checking bench for paralelo_serial_tx
module tb_paralelo_serial_tx;

   logic       clk;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       data_out;
   logic       load;
   logic       active;
   logic       is_data;

   int checks = 0;
   int errors = 0;

   logic [15:0] lfsr_m;

   paralelo_serial_tx #(
      .COM_SYMBOL    (8'hBC),
      .MIN_COM_COUNT (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .valid_in (valid_in),
      .data_out (data_out),
      .load     (load),
      .active   (active),
      .is_data  (is_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference byte for a data slot; scrambler build runs the bench LFSR model
   task automatic model_data(input logic [7:0] d, output logic [7:0] e);
`ifdef SCRAMBLER_EN
      for (int k = 7; k >= 0; k--) begin
         e[k] = d[k] ^ lfsr_m[15];
         lfsr_m = {lfsr_m[14:0], 1'b0} ^ (lfsr_m[15] ? 16'h0039 : 16'h0000);
      end
`else
      e = d;
`endif
   endtask

   // Entered at a negedge with load high; presents d/v for the load edge, scrambles data_in afterwards, collects 8 bits
   task automatic send_byte(input logic [7:0] d, input logic v, input logic [7:0] exp_b,
                            input logic exp_id, input string tag);
      logic [7:0] b;
      check_value({tag, "_load"}, 32'(load), 32'd1);
      data_in  = d;
      valid_in = v;
      b = 8'h00;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         if (k == 0) begin
            #1;
            data_in = ~d;
         end
         @(negedge clk);
         b = {b[6:0], data_out};
         if (k == 0) begin
            check_value({tag, "_is_data"}, 32'(is_data), 32'(exp_id));
            check_value({tag, "_load_low"}, 32'(load), 32'd0);
         end
      end
      check_value({tag, "_byte"}, 32'(b), 32'(exp_b));
   endtask

   task automatic tx_com(input logic [7:0] d, input logic v, input string tag);
      lfsr_m = 16'hFFFF;
      send_byte(d, v, 8'hBC, 1'b0, tag);
   endtask

   task automatic tx_data(input logic [7:0] d, input string tag);
      logic [7:0] e;
      model_data(d, e);
      send_byte(d, 1'b1, e, 1'b1, tag);
   endtask

   initial begin
      reset    = 1'b0;
      data_in  = 8'hA5;
      valid_in = 1'b1;
      lfsr_m   = 16'hFFFF;
      repeat (2) @(negedge clk);
      check_value("rst_data_out", 32'(data_out), 32'd0);
      check_value("rst_load", 32'(load), 32'd1);
      check_value("rst_active", 32'(active), 32'd0);
      check_value("rst_is_data", 32'(is_data), 32'd0);

      // Training burst ignores valid data
      reset = 1'b1;
      tx_com(8'hA5, 1'b1, "train0");
      tx_com(8'hA5, 1'b1, "train1");
      tx_com(8'hA5, 1'b1, "train2");
      check_value("active_before_4th", 32'(active), 32'd0);
      tx_com(8'hA5, 1'b1, "train3");
      check_value("active_after_4th", 32'(active), 32'd1);
      tx_data(8'hA5, "first_data");

      // Back-to-back data slots
      tx_data(8'h01, "d01");
      tx_data(8'h80, "d80");
      tx_data(8'hFF, "dff");

      // Valid toggling fills the empty slot with COM
      tx_data(8'h3C, "gap_a");
      tx_com(8'h3C, 1'b0, "gap_com");
      tx_data(8'h3C, "gap_b");

      // A data byte equal to COM is still data
      tx_data(8'hBC, "com_as_data");

      // Scrambler reseed pattern (verbatim 0x00 in default build)
      tx_com(8'h00, 1'b0, "pre_zero_com");
      tx_data(8'h00, "zero_a");
      tx_com(8'h00, 1'b0, "mid_zero_com");
      tx_data(8'h00, "zero_b");
      check_value("active_steady", 32'(active), 32'd1);

      // Reset three bits into a data byte
      check_value("mid_rst_load", 32'(load), 32'd1);
      data_in  = 8'h5A;
      valid_in = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_value("mid_rst_data_out", 32'(data_out), 32'd0);
      check_value("mid_rst_active", 32'(active), 32'd0);
      check_value("mid_rst_load_hi", 32'(load), 32'd1);
      check_value("mid_rst_is_data", 32'(is_data), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tx_com(8'h5A, 1'b1, "retrain0");
      tx_com(8'h5A, 1'b1, "retrain1");
      tx_com(8'h5A, 1'b1, "retrain2");
      tx_com(8'h5A, 1'b1, "retrain3");
      tx_data(8'h5A, "post_rst_data");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
